// File: rtl/parity_scan_pkg.sv
// Shared types and the parity check rule for the parity scan engine.
package parity_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Widest data word the shared parity function accepts; narrower words are zero-extended.
  localparam int PAR_MAX_W = 256;

  function automatic logic parity_ok(input logic [PAR_MAX_W-1:0] data,
                                     input logic                 par,
                                     input logic                 odd);
    return (^{data, par}) == odd;
  endfunction

endpackage

// File: rtl/parity_chk.sv
// Combinational word+parity check: flags a word whose XOR reduction differs from the expected sense.
module parity_chk
  import parity_scan_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  input  logic              par,
  input  logic              odd,
  output logic              mismatch
);

  assign mismatch = !parity_ok(PAR_MAX_W'(data), par, odd);

endmodule

// File: rtl/parity_scan_engine.sv
// Memory parity scrubber: walks all banks issuing one read per cycle and checks each returned word.
// Optional build macro PARITY_SCAN_ERR_INJECT_EN adds inj_en/inj_addr to force a mismatch for self-test.
module parity_scan_engine
  import parity_scan_pkg::*;
#(
  parameter int                   DATA_W    = 8,
  parameter int                   ADDR_W    = 3,
  parameter int                   NUM_BANKS = 2,
  parameter logic [NUM_BANKS-1:0] ODD_MASK  = 2'b01,
  parameter int                   ERR_CNT_W = 8,
  localparam int                  BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int                  AW        = BANK_W + ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 cont,
`ifdef PARITY_SCAN_ERR_INJECT_EN
  input  logic                 inj_en,
  input  logic [AW-1:0]        inj_addr,
`endif
  output logic                 busy,
  output logic                 done,
  output logic                 rd_en,
  output logic [AW-1:0]        rd_addr,
  input  logic [DATA_W-1:0]    rd_data,
  input  logic                 rd_par,
  output logic                 err_valid,
  output logic [AW-1:0]        err_addr,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 first_vld,
  output logic [AW-1:0]        first_addr,
  output state_t               dbg_state
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_BANKS * (2 ** ADDR_W) - 1);
  localparam int            MASK_W    = 2 ** BANK_W;
  // Padded so every encodable bank index selects a defined bit.
  localparam logic [MASK_W-1:0] ODD_MASK_EXT = MASK_W'(ODD_MASK);

  state_t        state, state_nxt;
  logic          drain_cnt;
  logic [AW-1:0] addr;
  logic          last_issue;
  logic          p_vld;
  logic          p_last;
  logic [AW-1:0] p_addr;
  logic          inj_hit;
  logic          odd_sense;
  logic          mismatch;
  logic          hit;

  assign rd_en      = (state == SCAN);
  assign rd_addr    = addr;
  assign busy       = (state != IDLE);
  assign last_issue = rd_en && (addr == LAST_ADDR);
  assign dbg_state  = state;

`ifdef PARITY_SCAN_ERR_INJECT_EN
  assign inj_hit = inj_en && (p_addr == inj_addr);
`else
  assign inj_hit = 1'b0;
`endif

  assign odd_sense = ODD_MASK_EXT[p_addr[AW-1:ADDR_W]] ^ inj_hit;
  assign hit       = p_vld && mismatch;

  parity_chk #(.DATA_W(DATA_W)) u_chk (
    .data     (rd_data),
    .par      (rd_par),
    .odd      (odd_sense),
    .mismatch (mismatch)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (last_issue && !cont) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage 1 carries the issued address to the data-return cycle; stage 2 registers the outcome.
  always_ff @(posedge clk) begin
    if (reset) begin
      drain_cnt  <= 1'b0;
      addr       <= '0;
      p_vld      <= 1'b0;
      p_last     <= 1'b0;
      p_addr     <= '0;
      err_valid  <= 1'b0;
      err_addr   <= '0;
      done       <= 1'b0;
      err_count  <= '0;
      first_vld  <= 1'b0;
      first_addr <= '0;
    end else begin
      drain_cnt <= (state == DRAIN) && !drain_cnt;
      if (rd_en) addr <= last_issue ? '0 : addr + AW'(1);
      p_vld     <= rd_en;
      p_last    <= last_issue;
      p_addr    <= addr;
      err_valid <= hit;
      done      <= p_vld && p_last;
      if (hit) err_addr <= p_addr;
      if (state == IDLE && start) begin
        addr       <= '0;
        err_count  <= '0;
        first_vld  <= 1'b0;
        first_addr <= '0;
      end else if (hit) begin
        if (err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
        if (!first_vld) begin
          first_vld  <= 1'b1;
          first_addr <= p_addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_parity_scan_engine.sv
// Self-checking bench for parity_scan_engine: default instance plus a 2-bit-counter instance on the same bus.
module tb_parity_scan_engine;
  import parity_scan_pkg::*;

  localparam logic [1:0] ODD_MASK = 2'b01;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset, start, cont;
  always #5 clk = ~clk;

  logic       inj_en;
  logic [3:0] inj_addr;

  logic       busy, done, rd_en, err_valid, first_vld;
  logic [3:0] rd_addr, err_addr, first_addr;
  logic [7:0] err_count;
  state_t     dbg_state;
  logic [7:0] rd_data = '0;
  logic       rd_par = 1'b0;

  logic       s_busy, s_done, s_rd_en, s_err_valid, s_first_vld;
  logic [3:0] s_rd_addr, s_err_addr, s_first_addr;
  logic [1:0] s_err_count;
  state_t     s_dbg_state;

  parity_scan_engine dut (
    .clk(clk), .reset(reset), .start(start), .cont(cont),
`ifdef PARITY_SCAN_ERR_INJECT_EN
    .inj_en(inj_en), .inj_addr(inj_addr),
`endif
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_par(rd_par), .err_valid(err_valid), .err_addr(err_addr),
    .err_count(err_count), .first_vld(first_vld), .first_addr(first_addr),
    .dbg_state(dbg_state)
  );

  parity_scan_engine #(.ERR_CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .cont(cont),
`ifdef PARITY_SCAN_ERR_INJECT_EN
    .inj_en(inj_en), .inj_addr(inj_addr),
`endif
    .busy(s_busy), .done(s_done), .rd_en(s_rd_en), .rd_addr(s_rd_addr),
    .rd_data(rd_data), .rd_par(rd_par), .err_valid(s_err_valid), .err_addr(s_err_addr),
    .err_count(s_err_count), .first_vld(s_first_vld), .first_addr(s_first_addr),
    .dbg_state(s_dbg_state)
  );

  // ---------------- memory model ----------------
  logic [7:0] mem_data [16];
  logic       mem_par  [16];

  always @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem_data[rd_addr];
      rd_par  <= mem_par[rd_addr];
    end
  end

  task automatic load_mem(input logic [15:0] bad);
    for (int a = 0; a < 16; a++) begin
      logic [7:0] d;
      logic       odd;
      d           = 8'($urandom_range(0, 255));
      odd         = ODD_MASK[a / 8];
      mem_data[a] = d;
      mem_par[a]  = ((($countones(d) % 2) == 1) ^ odd) ^ bad[a];
    end
  endtask

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err_valid"}, err_valid, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_first_vld"}, first_vld, 0);
    check({tag, "_first_addr"}, first_addr, 0);
    check({tag, "_err_addr"}, err_addr, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_sat_count"}, s_err_count, 0);
  endtask

  // Reference: pass p reads word a in cycle 1+16p+a after start; its check lands two cycles later.
  task automatic run_scan(input int passes, input logic [15:0] exp_mask);
    int         total, cnt, a;
    bit         fv, chk, exp_err, exp_done;
    logic [3:0] fa, got;
    total = 16 * passes;
    exp_q.delete();
    for (int p = 0; p < passes; p++)
      for (int w = 0; w < 16; w++)
        if (exp_mask[w]) exp_q.push_back(4'(w));
    @(negedge clk);
    start = 1'b1;
    cont  = (passes > 1);
    @(negedge clk);
    start = 1'b0;
    cnt = 0; fv = 0; fa = '0;
    for (int c = 1; c <= total + 3; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 10) start = 1'b1;
      if (c == 11) start = 1'b0;
      if (passes > 1 && c == 16 * (passes - 1) + 8) cont = 1'b0;
      chk      = (c >= 3) && (c <= total + 2);
      a        = (c - 3) % 16;
      exp_err  = chk && exp_mask[a];
      exp_done = chk && (a == 15);
      if (exp_err) begin
        cnt++;
        if (!fv) begin fv = 1; fa = 4'(a); end
      end
      check("rd_en", rd_en, (c <= total));
      if (c <= total) check("rd_addr", rd_addr, (c - 1) % 16);
      check("busy", busy, (c <= total + 2));
      check("done", done, exp_done);
      check("err_valid", err_valid, exp_err);
      if (err_valid) begin
        if (exp_q.size() == 0) check("err_extra", err_valid, 0);
        else begin
          got = exp_q.pop_front();
          check("err_addr", err_addr, got);
        end
      end
      check("err_count", err_count, (cnt > 255) ? 255 : cnt);
      check("sat_count", s_err_count, (cnt > 3) ? 3 : cnt);
      check("first_vld", first_vld, fv);
      if (fv) check("first_addr", first_addr, fa);
    end
    check("exp_q_left", exp_q.size(), 0);
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       odd;
    logic       exp_ok;
  } par_vec_t;

  typedef struct {
    logic [15:0] mask;
    int          passes;
    int          exp_cnt;
    int          exp_sat;
    int          exp_fv;
    int          exp_first;
  } scen_t;

  par_vec_t pv[8];
  scen_t    scen[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    pv[0] = '{8'h00, 1'b0, 1'b0, 1'b1};
    pv[1] = '{8'h01, 1'b0, 1'b0, 1'b0};
    pv[2] = '{8'h01, 1'b0, 1'b1, 1'b1};
    pv[3] = '{8'hFF, 1'b1, 1'b1, 1'b1};
    pv[4] = '{8'hFF, 1'b0, 1'b1, 1'b0};
    pv[5] = '{8'hA5, 1'b1, 1'b0, 1'b0};
    pv[6] = '{8'h80, 1'b0, 1'b1, 1'b1};
    pv[7] = '{8'h7F, 1'b1, 1'b0, 1'b1};

    scen[0] = '{16'h0000, 1, 0,  0, 0, 0};
    scen[1] = '{16'h1020, 1, 2,  2, 1, 5};
    scen[2] = '{16'h0008, 3, 3,  3, 1, 3};
    scen[3] = '{16'hFFFF, 1, 16, 3, 1, 0};
    scen[4] = '{16'h8000, 2, 2,  2, 1, 15};

    reset = 1'b1; start = 1'b0; cont = 1'b0; inj_en = 1'b0; inj_addr = '0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < 8; i++)
      check("parity_ok", parity_ok(PAR_MAX_W'(pv[i].data), pv[i].par, pv[i].odd), pv[i].exp_ok);

    for (int i = 0; i < 5; i++) begin
      load_mem(scen[i].mask);
      run_scan(scen[i].passes, scen[i].mask);
      check("tbl_count", err_count, scen[i].exp_cnt);
      check("tbl_sat", s_err_count, scen[i].exp_sat);
      check("tbl_first_vld", first_vld, scen[i].exp_fv);
      check("tbl_first_addr", first_addr, scen[i].exp_first);
    end

    for (int r = 0; r < 6; r++) begin
      logic [15:0] m;
      m = 16'($urandom);
      load_mem(m);
      run_scan($urandom_range(1, 2), m);
    end

`ifdef PARITY_SCAN_ERR_INJECT_EN
    inj_en = 1'b1; inj_addr = 4'd9;
    load_mem(16'h0000);
    run_scan(1, 16'h0200);
    check("inj_count", err_count, 1);
    check("inj_first", first_addr, 9);
    inj_en = 1'b0;
`endif

    // Reset mid-scan: everything clears and nothing in flight surfaces afterwards.
    load_mem(16'hFFFF);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_reset_count", err_count, 4);
    check("pre_reset_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check_idle_zero("mid_reset");
    reset = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check("post_reset_err", err_valid, 0);
      check("post_reset_done", done, 0);
      check("post_reset_busy", busy, 0);
    end

    // Reset and start together: reset wins, engine stays idle.
    load_mem(16'h0001);
    run_scan(1, 16'h0001);
    @(negedge clk); reset = 1'b1; start = 1'b1;
    @(negedge clk); reset = 1'b0; start = 1'b0;
    check_idle_zero("rst_start");
    @(negedge clk);
    check("rst_start_busy2", busy, 0);
    check("rst_start_rd_en2", rd_en, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
